// File: rtl/f_fetch_ctrl_if.sv
// Fetch-stage bus bundle for f_fetch_ctrl.
//   im_addr / im_instr             : combinational instruction-memory read
//   redirect_valid / redirect_pc   : branch/jump/jr redirect from later stages
//   out_valid / out_ready          : decode handshake
//   out_instr / out_pc             : head of the fetch queue
//   fault / fault_pc               : fetch halted on an illegal PC
// master = fetch controller, slave = surrounding pipeline / memory.
interface f_fetch_ctrl_if;
    logic [31:0] im_addr;
    logic [31:0] im_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;

    modport master (
        output im_addr,
        input  im_instr,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output fault,
        output fault_pc
    );

    modport slave (
        input  im_addr,
        output im_instr,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  fault,
        input  fault_pc
    );
endinterface

// File: rtl/f_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, reads the instruction memory, queues
// fetched words in a 2-entry FIFO for decode, applies redirects and halts on
// fetches outside the IM window or misaligned.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    f_fetch_ctrl_if.master (IM read, redirect, decode handshake, fault)
//
// Build option:
//   FETCH_BYPASS_EN  when defined, an empty queue forwards im_instr/pc straight
//                    to out_* (zero latency); otherwise out_* is registered only.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_RUN   | fetching sequentially from pc while queue space allows
// S_FAULT | halted on illegal pc; queue drains, waits for a redirect
module f_fetch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_DEPTH = 4096
) (
    input  logic          clk,
    input  logic          reset,
    f_fetch_ctrl_if.master bus
);
    // Window end in 33 bits so the upper bound cannot wrap.
    localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_DEPTH) << 2);

    typedef enum logic {S_RUN = 1'b0, S_FAULT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_pc, head_instr, tail_pc, tail_instr;

    logic        legal, fetch, push, pop_q, bypass;
    logic [1:0]  wr_slot;
    logic [32:0] pc_ext;

    assign pc_ext = {1'b0, pc_q};
    assign legal  = (pc_q[1:0] == 2'b00) && (pc_ext >= {1'b0, IM_BASE}) && (pc_ext < IM_LIMIT);

`ifdef FETCH_BYPASS_EN
    assign bypass = (count_q == 2'd0) && (state_q == S_RUN) && legal && !bus.redirect_valid;
`else
    assign bypass = 1'b0;
`endif

    // Queue pop only; a bypassed word never occupies a slot.
    assign pop_q   = (count_q != 2'd0) && bus.out_ready;
    assign fetch   = (state_q == S_RUN) && legal && !bus.redirect_valid
                     && ((count_q != 2'd2) || pop_q);
    assign push    = fetch && !(bypass && bus.out_ready);
    assign wr_slot = count_q - {1'b0, pop_q};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        count_d    = count_q + {1'b0, push} - {1'b0, pop_q};
        if (bus.redirect_valid) begin
            count_d = 2'd0;
        end
        case (state_q)
            S_RUN: begin
                if (bus.redirect_valid) begin
                    pc_d = bus.redirect_pc;
                end else if (fetch) begin
                    pc_d = pc_q + 32'd4;
                end else if (!legal) begin
                    state_d    = S_FAULT;
                    fault_pc_d = pc_q;
                end
            end
            S_FAULT: begin
                if (bus.redirect_valid) begin
                    state_d = S_RUN;
                    pc_d    = bus.redirect_pc;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_RUN;
            pc_q       <= PC_RESET;
            fault_pc_q <= 32'd0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
        end
    end

    // Head-is-slot-0 FIFO: head keeps its last value once the queue empties,
    // so out_pc/out_instr hold when nothing is valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_pc    <= 32'd0;
            head_instr <= 32'd0;
            tail_pc    <= 32'd0;
            tail_instr <= 32'd0;
        end else if (!bus.redirect_valid) begin
            if (pop_q && (count_q == 2'd2)) begin
                head_pc    <= tail_pc;
                head_instr <= tail_instr;
            end
            if (push) begin
                if (wr_slot == 2'd0) begin
                    head_pc    <= pc_q;
                    head_instr <= bus.im_instr;
                end else begin
                    tail_pc    <= pc_q;
                    tail_instr <= bus.im_instr;
                end
            end
        end
    end

    assign bus.im_addr  = pc_q;
    assign bus.fault    = (state_q == S_FAULT);
    assign bus.fault_pc = fault_pc_q;

`ifdef FETCH_BYPASS_EN
    assign bus.out_valid = (count_q != 2'd0) || bypass;
    assign bus.out_instr = bypass ? bus.im_instr : head_instr;
    assign bus.out_pc    = bypass ? pc_q : head_pc;
`else
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_instr = head_instr;
    assign bus.out_pc    = head_pc;
`endif
endmodule

// File: tb/tb_f_fetch_ctrl.sv
`timescale 1ns/1ps
module tb_f_fetch_ctrl;
    logic clk = 1'b0;
    logic reset;

    f_fetch_ctrl_if bus();

    f_fetch_ctrl dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int n_chk = 0;
    int n_bad = 0;

    logic [63:0] exp_q [$];

    logic        s_valid, s_fault;
    logic [31:0] s_pc, s_instr, s_addr, s_fault_pc;

    function automatic logic [31:0] im_word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h3C01_1234;
        if (a == 32'h0000_3004) return 32'h3421_5678;
        return a ^ 32'h5A5A_0000;
    endfunction

    assign bus.im_instr = im_word(bus.im_addr);

    // Window is 0x3000 + 4*4096 bytes, so the last legal word is 0x6FFC.
    function automatic bit im_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a <= 32'h0000_6FFC);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_stream(input logic [31:0] start);
        logic [31:0] a;
        a = start;
        for (int i = 0; i < 48 && im_legal(a); i++) begin
            exp_q.push_back({a, im_word(a)});
            a = a + 32'd4;
        end
    endtask

    // One clock cycle: drive inputs, sample at negedge, score any accepted word.
    task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic [63:0] e;
        bus.out_ready      = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        @(negedge clk);
        s_valid    = bus.out_valid;
        s_pc       = bus.out_pc;
        s_instr    = bus.out_instr;
        s_addr     = bus.im_addr;
        s_fault    = bus.fault;
        s_fault_pc = bus.fault_pc;
        if (s_valid && rdy) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pop", s_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", s_pc, e[63:32]);
                chk("sb_instr", s_instr, e[31:0]);
            end
        end
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        if (rv) begin
            exp_q.delete();
            expect_stream(rpc);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        chk("rst_im_addr", bus.im_addr, 32'h0000_3000);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_fault", bus.fault, 1'b0);
        chk("rst_fault_pc", bus.fault_pc, 32'h0);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst_out_instr", bus.out_instr, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        expect_stream(32'h0000_3000);
    endtask

    initial begin
        reset              = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        #2;
        apply_reset();

        // sequential fetch with ready held high
        cyc(1'b1, 1'b0, 32'h0);
        chk("t1_addr0", s_addr, 32'h0000_3000);
        chk("t1_valid0", s_valid, BYP);
        cyc(1'b1, 1'b0, 32'h0);
        chk("t1_addr1", s_addr, 32'h0000_3004);
        chk("t1_pc1", s_pc, BYP ? 32'h0000_3004 : 32'h0000_3000);
        cyc(1'b1, 1'b0, 32'h0);
        chk("t1_addr2", s_addr, 32'h0000_3008);
        chk("t1_pc2", s_pc, BYP ? 32'h0000_3008 : 32'h0000_3004);

        // stall from reset, then drain back-to-back
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            if (i >= 2) chk("t2_stall_addr", s_addr, 32'h0000_3008);
        end
        chk("t2_stall_pc", s_pc, 32'h0000_3000);
        chk("t2_stall_valid", s_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            chk("t2_drain_valid", s_valid, 1'b1);
            chk("t2_drain_pc", s_pc, 32'h0000_3000 + 32'(4 * i));
        end

        // redirect while full with a same-cycle pop
        cyc(1'b1, 1'b1, 32'h0000_3100);
        chk("t3_full_valid", s_valid, 1'b1);
        cyc(1'b1, 1'b0, 32'h0);
        chk("t3_flush_valid", s_valid, BYP);
        chk("t3_target_addr", s_addr, 32'h0000_3100);
        cyc(1'b1, 1'b0, 32'h0);
        chk("t3_target_valid", s_valid, 1'b1);
        chk("t3_target_pc", s_pc, BYP ? 32'h0000_3104 : 32'h0000_3100);

        // irregular ready pattern through the scoreboard
        for (int i = 0; i < 12; i++) begin
            cyc(((i % 3) != 0), 1'b0, 32'h0);
        end

        // misaligned redirect target
        cyc(1'b1, 1'b1, 32'h0000_3002);
        cyc(1'b1, 1'b0, 32'h0);
        chk("t4_mis_valid", s_valid, 1'b0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("t4_mis_fault", s_fault, 1'b1);
        chk("t4_mis_fault_pc", s_fault_pc, 32'h0000_3002);
        chk("t4_mis_valid2", s_valid, 1'b0);

        // last legal word, then sequential fetch off the end of the window
        cyc(1'b1, 1'b1, 32'h0000_6FFC);
        cyc(1'b1, 1'b0, 32'h0);
        chk("t4_end_fault_clr", s_fault, 1'b0);
        chk("t4_end_addr", s_addr, 32'h0000_6FFC);
        cyc(1'b1, 1'b0, 32'h0);
        chk("t4_end_valid", s_valid, !BYP);
        chk("t4_end_next_addr", s_addr, 32'h0000_7000);
        cyc(1'b1, 1'b0, 32'h0);
        chk("t4_end_fault", s_fault, 1'b1);
        chk("t4_end_fault_pc", s_fault_pc, 32'h0000_7000);

        // targets just outside the window on both sides
        cyc(1'b1, 1'b1, 32'h0000_7FFC);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("t4_hi_fault", s_fault, 1'b1);
        chk("t4_hi_fault_pc", s_fault_pc, 32'h0000_7FFC);
        cyc(1'b1, 1'b1, 32'h0000_2FFC);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("t4_lo_fault", s_fault, 1'b1);
        chk("t4_lo_fault_pc", s_fault_pc, 32'h0000_2FFC);

        // full queue in FAULT, then async reset mid-cycle
        cyc(1'b0, 1'b1, 32'h0000_6FF8);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0);
        chk("t5_pre_fault", bus.fault, 1'b1);
        chk("t5_pre_valid", bus.out_valid, 1'b1);
        chk("t5_pre_head", bus.out_pc, 32'h0000_6FF8);
        apply_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 32'h0);
        chk("t5_post_addr", s_addr, 32'h0000_3014);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
